// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
//   Shared definitions for the multiplexed 7-segment display blocks.
//   - seg_t           : 7-bit active-low segment vector, bit 6 = A ... bit 0 = G
//   - SEG_0 .. SEG_F  : hex glyphs (active-low)
//   - SEG_BLANK       : all segments off
//   - anode_onehot_n  : active-low one-hot digit enable, MAX_DIGITS wide;
//                       callers truncate it to their own digit count
// -----------------------------------------------------------------------------
package seg_pkg;

  localparam int MAX_DIGITS = 16;

  typedef logic [6:0] seg_t;

  //                            ABCDEFG
  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001111;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0000100;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b1100000;
  localparam seg_t SEG_C     = 7'b0110001;
  localparam seg_t SEG_D     = 7'b1000010;
  localparam seg_t SEG_E     = 7'b0110000;
  localparam seg_t SEG_F     = 7'b0111000;
  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low one-hot: bit idx is 0, all others 1.
  function automatic logic [MAX_DIGITS-1:0] anode_onehot_n(input logic [3:0] idx);
    logic [MAX_DIGITS-1:0] r;
    r      = '1;
    r[idx] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg_scan_driver_if
//   Bundle between the number-formatting logic (master) and the scan driver
//   (slave).
//   master -> slave : digits_in, dp_in, blink_mask, load, active_digits,
//                     lz_suppress, brightness
//   slave -> master : out_seg_anode, cathode, dp_n, frame_done
//
//   Handshake: load is a one-cycle strobe with no back-pressure. On every
//   rising clk edge where load is high, digits_in/dp_in/blink_mask are taken;
//   the slave never stalls, so there is no ready. The remaining master
//   signals are levels sampled continuously. frame_done is a one-cycle pulse.
// -----------------------------------------------------------------------------
interface seg_scan_driver_if
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DUTY_BITS  = 3
) ();

  localparam int AW = $clog2(NUM_DIGITS + 1);

  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    load;
  logic [AW-1:0]           active_digits;
  logic                    lz_suppress;
  logic [DUTY_BITS-1:0]    brightness;

  logic [NUM_DIGITS-1:0]   out_seg_anode;
  seg_t                    cathode;
  logic                    dp_n;
  logic                    frame_done;

  modport master (
    output digits_in, dp_in, blink_mask, load, active_digits, lz_suppress,
           brightness,
    input  out_seg_anode, cathode, dp_n, frame_done
  );

  modport slave (
    input  digits_in, dp_in, blink_mask, load, active_digits, lz_suppress,
           brightness,
    output out_seg_anode, cathode, dp_n, frame_done
  );

endinterface

// File: rtl/seg_glyph_decode.sv
// -----------------------------------------------------------------------------
// seg_glyph_decode
//   Combinational hex nibble to active-low 7-segment glyph (bit 6 = A).
//   Ports:
//     nibble_i  in  4  hex value 0..F
//     seg_o     out 7  active-low segments ABCDEFG
// -----------------------------------------------------------------------------
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//   Multiplexed 7-segment scan driver: up to NUM_DIGITS hex glyphs with
//   per-digit decimal point, leading-zero suppression, per-digit blink and
//   PWM brightness. Display data is double-buffered (pending -> shadow at
//   frame wrap) so a frame never mixes old and new data.
//   Ports:
//     clk    in  1  system clock
//     reset  in  1  synchronous, active-high
//     bus    slave modport of seg_scan_driver_if (data in, anode/cathode out)
//   All outputs are registered from the current index/slot state, so they
//   lag that state by one cycle.
// -----------------------------------------------------------------------------
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int TICK_DIV     = 250000,
  parameter int DUTY_BITS    = 3,
  parameter int BLINK_FRAMES = 50
) (
  input  logic              clk,
  input  logic              reset,
  seg_scan_driver_if.slave  bus
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int AW = $clog2(NUM_DIGITS + 1);
  localparam int SW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  // Cycles of one brightness step within a slot.
  localparam int unsigned QUANT = TICK_DIV >> DUTY_BITS;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [AW-1:0] N_MAX      = AW'(NUM_DIGITS);

  // Scan state
  logic [SW-1:0]         slot_q, slot_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [AW-1:0]         n_eff_q, n_eff_d;
  logic [FW-1:0]         frame_cnt_q, frame_cnt_d;
  logic                  blink_phase_q, blink_phase_d;

  // Double buffer
  logic [DW-1:0]         pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0] pend_blk_q, pend_blk_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [DW-1:0]         shadow_dig_q, shadow_dig_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [NUM_DIGITS-1:0] shadow_blk_q, shadow_blk_d;

  // Output registers
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  seg_t                  cathode_q, cathode_d;
  logic                  dp_n_q, dp_n_d;
  logic                  frame_done_q, frame_done_d;

  // Combinational helpers
  logic                  frame_start;
  logic [AW-1:0]         n_clamp;
  logic [AW-1:0]         n_eff;
  logic                  slot_end;
  logic                  last_idx;
  logic                  wrap;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blk;
  seg_t                  glyph;
  logic                  nz_above;
  logic                  lz_blank;
  logic                  blink_blank;
  logic                  duty_on;

  // ---------------------------------------------------------------------------
  // Frame geometry. The digit count is latched on the first cycle of each
  // frame (index 0, slot 0); during that cycle the live clamped value is used
  // directly so the first frame after reset already honours active_digits.
  // ---------------------------------------------------------------------------
  assign frame_start = (idx_q == '0) && (slot_q == '0);

  always_comb begin
    n_clamp = bus.active_digits;
    if (bus.active_digits == '0) begin
      n_clamp = AW'(1);
    end else if (bus.active_digits > N_MAX) begin
      n_clamp = N_MAX;
    end
  end

  assign n_eff    = frame_start ? n_clamp : n_eff_q;
  assign slot_end = (slot_q == SLOT_LAST);
  assign last_idx = (AW'(idx_q) == (n_eff - AW'(1)));
  assign wrap     = slot_end && last_idx;

  always_comb begin
    slot_d        = slot_end ? '0 : slot_q + SW'(1);
    idx_d         = idx_q;
    n_eff_d       = n_eff;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (slot_end) begin
      idx_d = last_idx ? '0 : idx_q + IW'(1);
    end
    if (wrap) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Double buffer. A load on the wrap cycle bypasses pending and goes straight
  // to shadow, so the newest data is never parked for an extra frame.
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_dig_d   = pend_dig_q;
    pend_dp_d    = pend_dp_q;
    pend_blk_d   = pend_blk_q;
    pend_valid_d = pend_valid_q;
    shadow_dig_d = shadow_dig_q;
    shadow_dp_d  = shadow_dp_q;
    shadow_blk_d = shadow_blk_q;
    if (wrap) begin
      pend_valid_d = 1'b0;
      if (bus.load) begin
        shadow_dig_d = bus.digits_in;
        shadow_dp_d  = bus.dp_in;
        shadow_blk_d = bus.blink_mask;
      end else if (pend_valid_q) begin
        shadow_dig_d = pend_dig_q;
        shadow_dp_d  = pend_dp_q;
        shadow_blk_d = pend_blk_q;
      end
    end else if (bus.load) begin
      pend_dig_d   = bus.digits_in;
      pend_dp_d    = bus.dp_in;
      pend_blk_d   = bus.blink_mask;
      pend_valid_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Current digit content
  // ---------------------------------------------------------------------------
  assign cur_nib = shadow_dig_q[{idx_q, 2'b00} +: 4];
  assign cur_dp  = shadow_dp_q[idx_q];
  assign cur_blk = shadow_blk_q[idx_q];

  seg_glyph_decode u_decode (
    .nibble_i (cur_nib),
    .seg_o    (glyph)
  );

  // A digit is a leading zero when it and every scanned digit to its left
  // are zero. Digits beyond n_eff are not scanned and do not count.
  always_comb begin
    nz_above = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((j >= int'(idx_q)) && (j < int'(n_eff)) &&
          (shadow_dig_q[4*j +: 4] != 4'h0)) begin
        nz_above = 1'b1;
      end
    end
  end

  assign lz_blank    = bus.lz_suppress && (idx_q != '0) && !nz_above;
  assign blink_blank = cur_blk && blink_phase_q;

  // The anode is on for the first (brightness+1) steps of each slot, so
  // all-ones brightness covers the whole slot.
  assign duty_on = (32'(slot_q) <
                    ((32'(bus.brightness) + 32'd1) * QUANT));

  always_comb begin
    anode_d      = duty_on ? NUM_DIGITS'(anode_onehot_n(4'(idx_q))) : '1;
    // LZ blanking drops the glyph only; blink drops glyph and dp.
    cathode_d    = (lz_blank || blink_blank) ? SEG_BLANK : glyph;
    dp_n_d       = blink_blank ? 1'b1 : ~cur_dp;
    frame_done_d = wrap;
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q        <= '0;
      idx_q         <= '0;
      n_eff_q       <= AW'(1);
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      pend_dig_q    <= '0;
      pend_dp_q     <= '0;
      pend_blk_q    <= '0;
      pend_valid_q  <= 1'b0;
      shadow_dig_q  <= '0;
      shadow_dp_q   <= '0;
      shadow_blk_q  <= '0;
      anode_q       <= '1;
      cathode_q     <= SEG_BLANK;
      dp_n_q        <= 1'b1;
      frame_done_q  <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      idx_q         <= idx_d;
      n_eff_q       <= n_eff_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      pend_dig_q    <= pend_dig_d;
      pend_dp_q     <= pend_dp_d;
      pend_blk_q    <= pend_blk_d;
      pend_valid_q  <= pend_valid_d;
      shadow_dig_q  <= shadow_dig_d;
      shadow_dp_q   <= shadow_dp_d;
      shadow_blk_q  <= shadow_blk_d;
      anode_q       <= anode_d;
      cathode_q     <= cathode_d;
      dp_n_q        <= dp_n_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign bus.out_seg_anode = anode_q;
  assign bus.cathode       = cathode_q;
  assign bus.dp_n          = dp_n_q;
  assign bus.frame_done    = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
//   Frame-level scoreboard for seg_scan_driver (4 digits, 16-cycle slots,
//   2 duty bits, 2-frame blink half-period). Before each frame the expected
//   per-cycle output word {frame_done, anode, cathode, dp_n} is pushed to
//   exp_q from the display contents the frame should show; each cycle the
//   observed word is popped and compared.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

  localparam int ND = 4;
  localparam int TD = 16;
  localparam int DB = 2;
  localparam int BF = 2;
  localparam int W  = 13;

  localparam logic [W-1:0] RESET_WORD = {1'b0, 4'hF, 7'h7F, 1'b1};

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  seg_scan_driver_if #(.NUM_DIGITS(ND), .DUTY_BITS(DB)) bus ();

  seg_scan_driver #(
    .NUM_DIGITS   (ND),
    .TICK_DIV     (TD),
    .DUTY_BITS    (DB),
    .BLINK_FRAMES (BF)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           fnum    = 0;

  // Hex glyphs, active-low, bit 6 = A .. bit 0 = G
  logic [6:0] glyph_tb [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  task automatic check_eq(input string tag, input logic [W-1:0] got,
                          input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] dut_word();
    return {bus.frame_done, bus.out_seg_anode, bus.cathode, bus.dp_n};
  endfunction

  // Expected words for one whole frame of n digits.
  task automatic predict_frame(input int n, input logic [15:0] dig,
                               input logic [3:0] dp, input logic [3:0] blk,
                               input logic lz, input int bright);
    logic       phase;
    logic [3:0] an;
    logic [3:0] nib;
    logic [6:0] cat;
    logic       dpn;
    logic       nz;
    logic       bl_lz;
    logic       bl_bk;
    phase = ((fnum / BF) % 2) == 1;
    for (int k = 0; k < n * TD; k++) begin
      int idx;
      int slot;
      idx  = k / TD;
      slot = k % TD;
      an   = 4'hF;
      if (slot < (bright + 1) * (TD >> DB)) an[idx] = 1'b0;
      nib = dig[4*idx +: 4];
      nz  = 1'b0;
      for (int j = idx; j < n; j++) begin
        if (dig[4*j +: 4] != 4'h0) nz = 1'b1;
      end
      bl_lz = lz && (idx != 0) && !nz;
      bl_bk = blk[idx] && phase;
      cat   = (bl_lz || bl_bk) ? 7'h7F : glyph_tb[nib];
      dpn   = bl_bk ? 1'b1 : ~dp[idx];
      exp_q.push_back({(k == n * TD - 1), an, cat, dpn});
    end
  endtask

  task automatic check_frame(input int n, input logic [15:0] dig,
                             input logic [3:0] dp, input logic [3:0] blk,
                             input logic lz, input int bright);
    logic [W-1:0] exp_w;
    predict_frame(n, dig, dp, blk, lz, bright);
    for (int k = 0; k < n * TD; k++) begin
      @(negedge clk);
      exp_w = exp_q.pop_front();
      check_eq($sformatf("f%0d_k%0d", fnum, k), dut_word(), exp_w);
    end
    fnum++;
  endtask

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic do_load(input logic [15:0] dig, input logic [3:0] dp,
                         input logic [3:0] blk);
    bus.digits_in  = dig;
    bus.dp_in      = dp;
    bus.blink_mask = blk;
    bus.load       = 1'b1;
    @(negedge clk);
    bus.load       = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bus.digits_in     = '0;
    bus.dp_in         = '0;
    bus.blink_mask    = '0;
    bus.load          = 1'b0;
    bus.active_digits = 3'd4;
    bus.lz_suppress   = 1'b0;
    bus.brightness    = 2'd3;

    reset = 1'b1;
    wait_neg(3);
    check_eq("reset", dut_word(), RESET_WORD);
    reset = 1'b0;

    // Frame 0: cleared shadow; load 12AF mid-frame (pending only)
    fork
      check_frame(4, 16'h0000, 4'b0000, 4'b0000, 1'b0, 3);
      begin wait_neg(11); do_load(16'h12AF, 4'b0100, 4'b0000); end
    join
    // Frame 1: F,A,2,1 with dp on digit 2
    fork
      check_frame(4, 16'h12AF, 4'b0100, 4'b0000, 1'b0, 3);
      begin wait_neg(21); do_load(16'h0050, 4'b1000, 4'b0000); end
    join
    bus.lz_suppress = 1'b1;
    // Frame 2: leading zeros blanked, blanked digit 3 keeps its dp;
    // two loads this frame, the second must win
    fork
      check_frame(4, 16'h0050, 4'b1000, 4'b0000, 1'b1, 3);
      begin
        wait_neg(4);  do_load(16'h3333, 4'b0000, 4'b0000);
        wait_neg(25); do_load(16'h0000, 4'b0000, 4'b0000);
      end
    join
    // Frame 3: all zero, only digit 0 lit
    fork
      check_frame(4, 16'h0000, 4'b0000, 4'b0000, 1'b1, 3);
      begin wait_neg(40); do_load(16'h12AF, 4'b0001, 4'b0001); end
    join
    bus.lz_suppress = 1'b0;
    bus.brightness  = 2'd0;
    // Frame 4: minimum duty, blink phase 0 -> digit 0 shown
    check_frame(4, 16'h12AF, 4'b0001, 4'b0001, 1'b0, 0);
    bus.brightness = 2'd2;
    // Frame 5: 3/4 duty
    check_frame(4, 16'h12AF, 4'b0001, 4'b0001, 1'b0, 2);
    // Frame 6: blink phase 1 -> digit 0 glyph and dp blank; mid-frame
    // active_digits and load changes must not disturb this frame
    fork
      check_frame(4, 16'h12AF, 4'b0001, 4'b0001, 1'b0, 2);
      begin
        wait_neg(31); bus.active_digits = 3'd2;
        wait_neg(10); do_load(16'h9999, 4'b0000, 4'b0000);
      end
    join
    // Frame 7: two digits, 32-cycle period; load on the wrap cycle
    fork
      check_frame(2, 16'h9999, 4'b0000, 4'b0000, 1'b0, 2);
      begin
        wait_neg(6);  bus.active_digits = 3'd0;
        wait_neg(25); do_load(16'h0007, 4'b0000, 4'b0000);
      end
    join
    // Frames 8, 9: active_digits 0 behaves as 1; wrap-cycle load shown
    check_frame(1, 16'h0007, 4'b0000, 4'b0000, 1'b0, 2);
    check_frame(1, 16'h0007, 4'b0000, 4'b0000, 1'b0, 2);

    // Reset mid-slot with a pending load outstanding
    bus.active_digits = 3'd4;
    bus.brightness    = 2'd3;
    wait_neg(2);
    do_load(16'hABCD, 4'b1111, 4'b0000);
    wait_neg(2);
    reset = 1'b1;
    wait_neg(1);
    check_eq("reset_mid", dut_word(), RESET_WORD);
    reset = 1'b0;
    fnum  = 0;
    // Scan restarts at digit 0 with cleared shadow; pending load is gone
    check_frame(4, 16'h0000, 4'b0000, 4'b0000, 1'b0, 3);
    check_frame(4, 16'h0000, 4'b0000, 4'b0000, 1'b0, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach summary, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
